// File: rtl/uc_multicycle_if.sv
// uc_multicycle_if: control/status bundle between the multicycle controller and its datapath.
// Revision 1.0 - initial release.
`default_nettype none

interface uc_multicycle_if;
  logic [6:0]  opcode;
  logic [3:0]  alu_flags;
  logic        ir_en;
  logic        pc_en;
  logic        rf_we;
  logic        d_mem_we;
  logic        pc_src;
  logic        rf_src;
  logic        alu_src;
  logic [3:0]  alu_cmd;
  logic        halted;
  logic [2:0]  state_dbg;
  logic [31:0] instr_count;

  modport master (
    input  opcode, alu_flags,
    output ir_en, pc_en, rf_we, d_mem_we, pc_src, rf_src, alu_src,
           alu_cmd, halted, state_dbg, instr_count
  );

  modport slave (
    output opcode, alu_flags,
    input  ir_en, pc_en, rf_we, d_mem_we, pc_src, rf_src, alu_src,
           alu_cmd, halted, state_dbg, instr_count
  );
endinterface

`default_nettype wire

// File: rtl/uc_multicycle.sv
// uc_multicycle: Moore control FSM for a multicycle RISC datapath; UC_INSTR_COUNT_EN adds a retired-instruction counter.
// Revision 1.0 - initial release.
`default_nettype none

module uc_multicycle (
  input  logic            clk,
  input  logic            reset,
  uc_multicycle_if.master bus
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [3:0] CMD_ADD  = 4'b0000;
  localparam logic [3:0] CMD_SUB  = 4'b0001;
  localparam logic [3:0] CMD_RFN  = 4'b0010;
  localparam logic [3:0] CMD_IFN  = 4'b0011;

  logic [2:0] state_q, state_d;
  logic [6:0] opcode_q, opcode_d;
  logic       legal_op;
  logic       unused_flags;

  // Branch flags are consumed by the datapath's PC mux, not by the controller.
  assign unused_flags = ^bus.alu_flags;

  always_comb begin
    legal_op = 1'b0;
    case (bus.opcode)
      OP_R, OP_I, OP_LD, OP_ST, OP_BEQ: legal_op = 1'b1;
      default:                          legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (legal_op) begin
          state_d  = S_EXECUTE;
          opcode_d = bus.opcode;
        end else begin
          state_d  = S_HALT;
        end
      end
      S_EXECUTE: begin
        case (opcode_q)
          OP_R, OP_I:   state_d = S_WRITEBACK;
          OP_LD, OP_ST: state_d = S_MEM;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM:       state_d = (opcode_q == OP_LD) ? S_WRITEBACK : S_FETCH;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    bus.ir_en     = 1'b0;
    bus.pc_en     = 1'b0;
    bus.rf_we     = 1'b0;
    bus.d_mem_we  = 1'b0;
    bus.pc_src    = 1'b0;
    bus.rf_src    = 1'b0;
    bus.alu_src   = 1'b0;
    bus.alu_cmd   = CMD_ADD;
    bus.halted    = 1'b0;
    bus.state_dbg = state_q;

    case (state_q)
      S_FETCH: bus.ir_en = 1'b1;
      S_EXECUTE: begin
        if (opcode_q == OP_BEQ) begin
          bus.pc_src = 1'b1;
          bus.pc_en  = 1'b1;
        end
      end
      S_MEM: begin
        if (opcode_q == OP_ST) begin
          bus.d_mem_we = 1'b1;
          bus.pc_en    = 1'b1;
        end
      end
      S_WRITEBACK: begin
        bus.rf_we  = 1'b1;
        bus.pc_en  = 1'b1;
        bus.rf_src = (opcode_q == OP_LD);
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase

    // ALU controls stay stable for every post-decode cycle of the instruction.
    if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) begin
      case (opcode_q)
        OP_R:         bus.alu_cmd = CMD_RFN;
        OP_I: begin
          bus.alu_src = 1'b1;
          bus.alu_cmd = CMD_IFN;
        end
        OP_LD, OP_ST: bus.alu_src = 1'b1;
        OP_BEQ:       bus.alu_cmd = CMD_SUB;
        default:      ;
      endcase
    end
  end

`ifdef UC_INSTR_COUNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (bus.pc_en) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uc_multicycle.sv
// tb_uc_multicycle: randomized self-checking bench for uc_multicycle against a cycle-table model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_uc_multicycle;

  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_LD  = 2;
  localparam int CLS_ST  = 3;
  localparam int CLS_BEQ = 4;
  localparam int CLS_ILL = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

`ifdef UC_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  st;
    logic        ir_en;
    logic        pc_en;
    logic        rf_we;
    logic        d_mem_we;
    logic        pc_src;
    logic        rf_src;
    logic        alu_src;
    logic [3:0]  alu_cmd;
    logic        halted;
    logic [31:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uc_multicycle_if bus();

  uc_multicycle dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_cls = 0;
  int          m_idx = 0;
  logic [31:0] m_cnt = '0;
  bit          exp_valid = 1'b0;
  obs_t        exp_o;
  obs_t        act_o;
  logic [11:0] trace;

  function automatic int classify(input logic [6:0] op);
    case (op)
      OP_R:    return CLS_R;
      OP_I:    return CLS_I;
      OP_LD:   return CLS_LD;
      OP_ST:   return CLS_ST;
      OP_BEQ:  return CLS_BEQ;
      default: return CLS_ILL;
    endcase
  endfunction

  function automatic int ilen(input int c);
    case (c)
      CLS_R, CLS_I: return 4;
      CLS_LD:       return 5;
      CLS_ST:       return 4;
      CLS_BEQ:      return 3;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [2:0] state_of(input int c, input int i);
    if (i == 0) return 3'd0;
    if (i == 1) return 3'd1;
    if (c == CLS_ILL) return 3'd5;
    if (i == 2) return 3'd2;
    if (i == 3) return (c == CLS_LD || c == CLS_ST) ? 3'd3 : 3'd4;
    return 3'd4;
  endfunction

  // Expected outputs from instruction class and cycle position within it.
  function automatic obs_t expect_of(input int c, input int i, input logic [31:0] cnt);
    obs_t o;
    o          = '0;
    o.st       = state_of(c, i);
    o.ir_en    = (i == 0);
    o.halted   = (o.st == 3'd5);
    o.pc_en    = (c != CLS_ILL) && (i >= 2) && (i == ilen(c) - 1);
    o.rf_we    = (o.st == 3'd4);
    o.rf_src   = (o.st == 3'd4) && (c == CLS_LD);
    o.d_mem_we = (o.st == 3'd3) && (c == CLS_ST);
    o.pc_src   = (c == CLS_BEQ) && (i == 2);
    if (i >= 2) begin
      case (c)
        CLS_R:  o.alu_cmd = 4'b0010;
        CLS_I:  begin o.alu_src = 1'b1; o.alu_cmd = 4'b0011; end
        CLS_LD, CLS_ST: o.alu_src = 1'b1;
        CLS_BEQ: o.alu_cmd = 4'b0001;
        default: ;
      endcase
    end
    o.cnt = CNT_EN ? cnt : 32'd0;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one edge, then advance the model across that edge.
  task automatic cycle(input bit rst, input logic [6:0] op);
    reset         = rst;
    bus.opcode    = op;
    bus.alu_flags = 4'($urandom);
    @(posedge clk);
    #1;
    if (rst) begin
      m_idx = 0;
      m_cnt = '0;
    end else if (m_idx == 0) begin
      m_idx = 1;
    end else if (m_idx == 1) begin
      m_cls = classify(op);
      m_idx = 2;
    end else if (m_cls == CLS_ILL) begin
      m_idx = m_idx;
    end else if (m_idx == ilen(m_cls) - 1) begin
      m_cnt = m_cnt + 32'd1;
      m_idx = 0;
    end else begin
      m_idx = m_idx + 1;
    end
    exp_o     = expect_of(m_cls, m_idx, m_cnt);
    exp_valid = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op);
    int guard;
    guard = 0;
    do begin
      cycle(1'b0, (m_idx == 1) ? op : 7'($urandom));
      guard++;
    end while (m_idx != 0 && !(m_cls == CLS_ILL && m_idx >= 2) && guard < 10);
  endtask

  function automatic logic [6:0] pick_op();
    int r;
    r = $urandom_range(0, 11);
    case (r)
      0, 1:    return OP_R;
      2, 3:    return OP_I;
      4, 5:    return OP_LD;
      6, 7:    return OP_ST;
      8, 9:    return OP_BEQ;
      10:      return 7'h7f;
      default: return 7'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      act_o = {bus.state_dbg, bus.ir_en, bus.pc_en, bus.rf_we, bus.d_mem_we,
               bus.pc_src, bus.rf_src, bus.alu_src, bus.alu_cmd, bus.halted,
               bus.instr_count};
      checks++;
      if (act_o !== exp_o) begin
        errors++;
        $display("FAIL outputs at %0t: got %h expected %h", $time, act_o, exp_o);
      end
    end
  end

  initial begin
    bus.opcode    = '0;
    bus.alu_flags = '0;

    cycle(1'b1, 7'd0);
    cycle(1'b1, 7'd0);
    check("reset_state", 32'(bus.state_dbg), 32'd0);
    check("reset_ir_en", 32'(bus.ir_en), 32'd1);
    check("reset_enables", 32'({bus.pc_en, bus.rf_we, bus.d_mem_we, bus.pc_src,
                                bus.rf_src, bus.alu_src, bus.halted}), 32'd0);
    check("reset_alu_cmd", 32'(bus.alu_cmd), 32'd0);

    cycle(1'b0, OP_R); check("R_decode", 32'(bus.state_dbg), 32'd1);
    cycle(1'b0, OP_R); check("R_execute", 32'(bus.state_dbg), 32'd2);
    check("R_cmd_execute", 32'(bus.alu_cmd), 32'b0010);
    cycle(1'b0, OP_R); check("R_writeback", 32'(bus.state_dbg), 32'd4);
    check("R_wb_strobes", 32'({bus.rf_we, bus.pc_en, bus.alu_cmd}), 32'b11_0010);
    cycle(1'b0, OP_R); check("R_fetch", 32'(bus.state_dbg), 32'd0);

    trace = '0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, OP_LD);
      trace = {trace[8:0], bus.state_dbg};
      if (k == 3) check("LD_wb_src", 32'({bus.rf_src, bus.rf_we, bus.d_mem_we}), 32'b110);
    end
    check("LD_trace", 32'(trace), 32'({3'd1, 3'd2, 3'd3, 3'd4}));
    cycle(1'b0, OP_LD);

    cycle(1'b0, OP_ST); cycle(1'b0, OP_ST); cycle(1'b0, OP_ST);
    check("ST_mem", 32'({bus.state_dbg, bus.d_mem_we, bus.pc_en}), 32'({3'd3, 2'b11}));
    cycle(1'b0, OP_ST);
    cycle(1'b0, OP_BEQ); cycle(1'b0, OP_BEQ);
    check("BEQ_execute", 32'({bus.pc_src, bus.pc_en, bus.alu_cmd}), 32'b11_0001);
    cycle(1'b0, OP_BEQ);
    check("BEQ_done", 32'(bus.state_dbg), 32'd0);

    cycle(1'b1, 7'd0);
    cycle(1'b0, OP_ST); cycle(1'b0, OP_ST); cycle(1'b0, OP_ST);
    cycle(1'b1, OP_ST);
    check("abort_state", 32'({bus.state_dbg, bus.d_mem_we}), 32'd0);
    check("abort_count", bus.instr_count, 32'd0);

    run_instr(7'h7f);
    repeat (20) cycle(1'b0, 7'($urandom));
    check("halt_held", 32'({bus.state_dbg, bus.halted, bus.ir_en, bus.pc_en,
                            bus.rf_we, bus.d_mem_we}), 32'({3'd5, 5'b10000}));
    cycle(1'b1, 7'd0);
    check("halt_reset", 32'({bus.state_dbg, bus.halted}), 32'd0);

`ifdef UC_INSTR_COUNT_EN
    cycle(1'b1, 7'd0);
    repeat (3) run_instr(OP_R);
    repeat (2) run_instr(OP_LD);
    check("count_five", bus.instr_count, 32'd5);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    m_cnt     = 32'hFFFF_FFFF;
    exp_o.cnt = m_cnt;
    run_instr(OP_R);
    check("count_wrap", bus.instr_count, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      bit r;
      r = ($urandom_range(0, 49) == 0) ||
          (m_cls == CLS_ILL && m_idx >= 2 && $urandom_range(0, 3) == 0);
      cycle(r, (m_idx == 1) ? pick_op() : 7'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uc_multicycle.md
UC_MULTICYCLE -- requirements
Module: uc_multicycle

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as listed below (clock and reset first).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instruction[6:0] from the datapath IR.
REQ-005 alu_flags  input  4  datapath ALU flags; bit 0 = zero (BEQ taken).
REQ-006 ir_en  output  1  load the IR with the fetched instruction.
REQ-007 pc_en  output  1  advance the PC (one pulse per retired instruction).
REQ-008 rf_we, d_mem_we, pc_src, rf_src, alu_src  output  1 each  datapath controls.
REQ-009 alu_cmd  output  4  0000 add, 0001 sub, 0010 R-funct decode, 0011 I-funct decode.
REQ-010 halted  output  1  high in HALT.
REQ-011 state_dbg  output  3  current state encoding.
REQ-012 instr_count  output  32  retired-instruction count (see Configuration).

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
REQ-014 Transitions SHALL be:
- FETCH->DECODE always.
- DECODE->EXECUTE for the legal opcodes 0110011 R, 0010011 I, 0000011 LD, 0100011 ST, 1100011 BEQ.
- DECODE->HALT for any other opcode.
REQ-015 EXECUTE SHALL go to:
- WRITEBACK for R/I.
- MEM for LD/ST.
- FETCH for BEQ.
REQ-016 MEM SHALL go to WRITEBACK for LD and to FETCH for ST; WRITEBACK->FETCH always.
REQ-017 HALT SHALL be exited only by reset.
REQ-018 opcode SHALL be registered into opcode_q on the DECODE->EXECUTE edge; outputs SHALL be Moore functions of state and opcode_q only.
REQ-019 ir_en SHALL be 1 only in FETCH.
REQ-020 From EXECUTE until the instruction ends, alu_src and alu_cmd SHALL be held per opcode_q:
- R: alu_src 0, cmd 0010.
- I: alu_src 1, cmd 0011.
- LD/ST: alu_src 1, cmd 0000.
- BEQ: alu_src 0, cmd 0001.
REQ-021 alu_src and alu_cmd SHALL be 0 and 0000 in all other states.
REQ-022 Cycle counts SHALL be: R/I 4 cycles, LD 5, ST 4, BEQ 3.
REQ-023 pc_en SHALL pulse for exactly one cycle in the final state of each instruction.
REQ-024 pc_src SHALL be 1 only in BEQ EXECUTE; the datapath gates it with alu_flags[0].
REQ-025 rf_we SHALL be 1 only in WRITEBACK.
REQ-026 rf_src SHALL be 1 only in LD WRITEBACK.
REQ-027 d_mem_we SHALL be 1 only in ST MEM.
REQ-028 In HALT, all enables SHALL be 0 and halted SHALL be 1.
REQ-029 No write enable (rf_we, d_mem_we, pc_en) SHALL ever be asserted for an illegal opcode.

Reset
REQ-030 While reset=1 at a rising edge, the next state SHALL be state=FETCH, opcode_q=0, and instr_count=0.
REQ-031 Outputs in the cycle after a reset edge SHALL be: ir_en=1, all other enables 0, alu_cmd=0000, halted=0.
REQ-032 Reset asserted mid-instruction (any state, including MEM with d_mem_we=1) SHALL abort the instruction with no further strobes.
REQ-033 Reset SHALL take priority over every transition.

Configuration
REQ-034 With UC_INSTR_COUNT_EN defined, instr_count SHALL increment by 1 on every clock edge where pc_en=1.
REQ-035 instr_count SHALL wrap from FFFFFFFF to 00000000.
REQ-036 Without UC_INSTR_COUNT_EN, instr_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-037 Reset, then opcode=0110011 held -> state_dbg 0,1,2,4,0; rf_we=1 and pc_en=1 only in cycle 4; alu_cmd=0010 in cycles 3-4.
REQ-038 opcode=0000011 -> five-cycle sequence 0,1,2,3,4; rf_src=rf_we=1 in WRITEBACK only; d_mem_we never 1.
REQ-039 opcode=0100011 then 1100011 -> ST: d_mem_we=1 and pc_en=1 in MEM, 4 cycles; BEQ: pc_src=1 and pc_en=1 in EXECUTE, 3 cycles; alu_cmd=0001 there.
REQ-040 opcode=1111111 at DECODE -> HALT; halted=1 held 20 cycles with all enables 0; reset -> FETCH.
REQ-041 Reset asserted during ST MEM -> next cycle state_dbg=0, d_mem_we=0, instr_count unchanged from before that store.
REQ-042 With UC_INSTR_COUNT_EN, run 3 R + 2 LD -> instr_count=5; force count to FFFFFFFF, retire 1 -> 00000000.
